apb_master_memif: RTL and testbench

APB_MASTER_MEMIF -- requirements
Module: apb_master_memif

---
 rtl/apb_master_memif.sv | 197 +++++++++++++++++++
 tb/tb_apb_master_memif.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_memif.sv
// apb_master_memif
// ----------------
// Bridges a simple valid/ack memory request port onto an APB completer.
// A request is accepted only while the FSM sits in IDLE (mready_o). Its
// address, direction, write data and strobes are captured straight into
// the APB output registers. The APB transfer then runs through the SETUP
// and ACCESS phases. The completion is returned as a one-cycle mack_o
// pulse, carrying mrdata_o/mresp_o.
//
// Optional feature (macro APB_TIMEOUT_EN):
//   When defined, an ACCESS-phase cycle counter aborts a transfer after
//   TIMEOUT_CYCLES cycles without pready_i. The abort completes with
//   mresp_o=1 and mrdata_o=0. When undefined, ACCESS waits indefinitely
//   and no counter exists.
//
// Ports:
//   clk_i, arst_i                   clock (rising edge), async active-high reset
//   mreq_i, mready_o                request valid / block idle and ready
//   maddr_i, mwe_i, mwdata_i,       request address, write enable,
//   mstrb_i                         write data and byte strobes
//   mack_o, mrdata_o, mresp_o       completion pulse, read data, error flag
//   psel_o, penable_o, pwrite_o     APB control
//   paddr_o, pwdata_o, pstrb_o      APB address, write data, strobes
//   pready_i, prdata_i, pslverr_i   APB completer response
module apb_master_memif #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic                    mreq_i,
  output logic                    mready_o,
  input  logic [ADDR_WIDTH-1:0]   maddr_i,
  input  logic                    mwe_i,
  input  logic [DATA_WIDTH-1:0]   mwdata_i,
  input  logic [DATA_WIDTH/8-1:0] mstrb_i,
  output logic                    mack_o,
  output logic [DATA_WIDTH-1:0]   mrdata_o,
  output logic                    mresp_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Reject configurations that cannot work: byte strobes need whole bytes,
  // and a zero-cycle timeout would never let a transfer reach ACCESS.
  if (TIMEOUT_CYCLES < 1 || (DATA_WIDTH % 8) != 0) begin : g_param_check
    $error("apb_master_memif: DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    psel_next;
  logic                    penable_next;
  logic                    pwrite_next;
  logic [ADDR_WIDTH-1:0]   paddr_next;
  logic [DATA_WIDTH-1:0]   pwdata_next;
  logic [STRB_WIDTH-1:0]   pstrb_next;
  logic                    mack_next;
  logic [DATA_WIDTH-1:0]   mrdata_next;
  logic                    mresp_next;

`ifdef APB_TIMEOUT_EN
  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMER_WIDTH-1:0] timer;
  logic [TIMER_WIDTH-1:0] timer_next;
`endif

  // The only combinational output: ready whenever no transfer is in flight.
  assign mready_o = (state == IDLE);

  // Next-state and next-output logic. Every registered output holds its
  // value by default, so APB address, data and strobes stay stable through
  // SETUP/ACCESS and keep their last value in IDLE. mack_o is the exception:
  // it defaults low so that it can only ever be a single-cycle pulse.
  always_comb begin
    state_next   = state;
    psel_next    = psel_o;
    penable_next = penable_o;
    pwrite_next  = pwrite_o;
    paddr_next   = paddr_o;
    pwdata_next  = pwdata_o;
    pstrb_next   = pstrb_o;
    mack_next    = 1'b0;
    mrdata_next  = mrdata_o;
    mresp_next   = mresp_o;
`ifdef APB_TIMEOUT_EN
    timer_next   = '0;
`endif

    case (state)
      IDLE: begin
        if (mreq_i) begin
          state_next   = SETUP;
          psel_next    = 1'b1;
          penable_next = 1'b0;
          pwrite_next  = mwe_i;
          paddr_next   = maddr_i;
          // Reads drive no strobes and leave the write data bus untouched.
          if (mwe_i) begin
            pwdata_next = mwdata_i;
            pstrb_next  = mstrb_i;
          end else begin
            pstrb_next  = '0;
          end
        end
      end

      SETUP: begin
        state_next   = ACCESS;
        penable_next = 1'b1;
      end

      ACCESS: begin
        if (pready_i) begin
          state_next   = IDLE;
          psel_next    = 1'b0;
          penable_next = 1'b0;
          mack_next    = 1'b1;
          mrdata_next  = pwrite_o ? '0 : prdata_i;
          mresp_next   = pslverr_i;
`ifdef APB_TIMEOUT_EN
        end else if (timer == TIMER_LAST) begin
          // This is the last ACCESS cycle allowed. Abandon the transfer
          // and report it as an error with no data.
          state_next   = IDLE;
          psel_next    = 1'b0;
          penable_next = 1'b0;
          mack_next    = 1'b1;
          mrdata_next  = '0;
          mresp_next   = 1'b1;
        end else begin
          timer_next   = timer + 1'b1;
`endif
        end
      end

      default: begin
        state_next   = IDLE;
        psel_next    = 1'b0;
        penable_next = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset clears everything immediately,
  // which also aborts any transfer in flight without a completion pulse.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state     <= IDLE;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      pstrb_o   <= '0;
      mack_o    <= 1'b0;
      mrdata_o  <= '0;
      mresp_o   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      timer     <= '0;
`endif
    end else begin
      state     <= state_next;
      psel_o    <= psel_next;
      penable_o <= penable_next;
      pwrite_o  <= pwrite_next;
      paddr_o   <= paddr_next;
      pwdata_o  <= pwdata_next;
      pstrb_o   <= pstrb_next;
      mack_o    <= mack_next;
      mrdata_o  <= mrdata_next;
      mresp_o   <= mresp_next;
`ifdef APB_TIMEOUT_EN
      timer     <= timer_next;
`endif
    end
  end

endmodule

// File: tb/tb_apb_master_memif.sv
// tb_apb_master_memif
// -------------------
// Directed testbench for apb_master_memif. The stimulus pushes the expected
// completion of each request into a queue. A separate monitor pops the queue
// and compares it on every mack_o pulse. APB phase behaviour is checked
// inline by the stimulus task.
// The timeout scenario is built only when APB_TIMEOUT_EN is defined.
module tb_apb_master_memif;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk;
  logic          arst;
  logic          mreq;
  logic          mready;
  logic [AW-1:0] maddr;
  logic          mwe;
  logic [DW-1:0] mwdata;
  logic [SW-1:0] mstrb;
  logic          mack;
  logic [DW-1:0] mrdata;
  logic          mresp;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  int checks = 0;
  int errors = 0;

  // Expected completions, packed as {mresp, mrdata}.
  logic [DW:0] exp_q[$];
  logic [DW:0] mon_exp;
  // Value pwdata_o is expected to hold across reads.
  logic [DW-1:0] last_wdata;

  apb_master_memif #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk),
    .arst_i(arst),
    .mreq_i(mreq),
    .mready_o(mready),
    .maddr_i(maddr),
    .mwe_i(mwe),
    .mwdata_i(mwdata),
    .mstrb_i(mstrb),
    .mack_o(mack),
    .mrdata_o(mrdata),
    .mresp_o(mresp),
    .psel_o(psel),
    .penable_o(penable),
    .pwrite_o(pwrite),
    .paddr_o(paddr),
    .pwdata_o(pwdata),
    .pstrb_o(pstrb),
    .pready_i(pready),
    .prdata_i(prdata),
    .pslverr_i(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the flow ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every completion pulse must match the oldest
  // outstanding expectation.
  always @(negedge clk) begin
    if (!arst && mack === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_mack: got mack_o=1 with mrdata 0x%08h, expected no completion", mrdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mrdata !== mon_exp[DW-1:0]) begin
          errors++;
          $display("[TB] FAIL mack_rdata: got 0x%08h, expected 0x%08h", mrdata, mon_exp[DW-1:0]);
        end
        checks++;
        if (mresp !== mon_exp[DW]) begin
          errors++;
          $display("[TB] FAIL mack_resp: got %0b, expected %0b", mresp, mon_exp[DW]);
        end
      end
    end
  end

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issues one request from IDLE and acts as the APB completer. pready is
  // asserted after wait_cycles ACCESS cycles. The task returns in the mack
  // cycle, so a following call exercises back-to-back acceptance. Garbage is
  // driven on mreq/maddr and on the APB response inputs wherever the design
  // must ignore them.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic we,
                               input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                               input int wait_cycles, input logic [DW-1:0] rdata,
                               input logic slverr);
    logic [DW-1:0] exp_pwdata;
    logic [SW-1:0] exp_pstrb;
    logic [DW-1:0] exp_rdata;
    exp_pwdata = we ? wdata : last_wdata;
    exp_pstrb  = we ? strb : '0;
    exp_rdata  = we ? '0 : rdata;
    if (we) last_wdata = wdata;

    checkOutput("idle_mready", 32'(mready), 1);
    exp_q.push_back({slverr, exp_rdata});
    mreq = 1'b1; maddr = addr; mwe = we; mwdata = wdata; mstrb = strb;
    @(posedge clk);
    #1;
    mreq = 1'b1; maddr = ~addr; mwe = ~we; mwdata = ~wdata; mstrb = ~strb;
    pready = 1'b1; prdata = 32'hBADC0DE0; pslverr = 1'b1;
    checkOutput("setup_psel", 32'(psel), 1);
    checkOutput("setup_penable", 32'(penable), 0);
    checkOutput("setup_mready", 32'(mready), 0);
    checkOutput("setup_paddr", 32'(paddr), 32'(addr));
    checkOutput("setup_pwrite", 32'(pwrite), 32'(we));
    checkOutput("setup_pwdata", pwdata, exp_pwdata);
    checkOutput("setup_pstrb", 32'(pstrb), 32'(exp_pstrb));
    checkOutput("setup_mack", 32'(mack), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i <= wait_cycles; i++) begin
      checkOutput("access_psel", 32'(psel), 1);
      checkOutput("access_penable", 32'(penable), 1);
      checkOutput("access_paddr", 32'(paddr), 32'(addr));
      checkOutput("access_pwrite", 32'(pwrite), 32'(we));
      checkOutput("access_pwdata", pwdata, exp_pwdata);
      checkOutput("access_pstrb", 32'(pstrb), 32'(exp_pstrb));
      checkOutput("access_mack", 32'(mack), 0);
      if (i == wait_cycles) begin
        mreq = 1'b0; pready = 1'b1; prdata = rdata; pslverr = slverr;
      end else begin
        pready = 1'b0; prdata = 32'hBAD00000 | 32'(i); pslverr = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    checkOutput("done_mack", 32'(mack), 1);
    checkOutput("done_psel", 32'(psel), 0);
    checkOutput("done_penable", 32'(penable), 0);
    checkOutput("done_mready", 32'(mready), 1);
    checkOutput("done_paddr_hold", 32'(paddr), 32'(addr));
    checkOutput("done_pstrb_hold", 32'(pstrb), 32'(exp_pstrb));
  endtask

  initial begin
    arst = 1'b1; mreq = 1'b0; maddr = '0; mwe = 1'b0; mwdata = '0; mstrb = '0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    last_wdata = '0;

    // Reset values.
    idleCycles(2);
    checkOutput("rst_psel", 32'(psel), 0);
    checkOutput("rst_penable", 32'(penable), 0);
    checkOutput("rst_pwrite", 32'(pwrite), 0);
    checkOutput("rst_mack", 32'(mack), 0);
    checkOutput("rst_mresp", 32'(mresp), 0);
    checkOutput("rst_paddr", 32'(paddr), 0);
    checkOutput("rst_pwdata", pwdata, 0);
    checkOutput("rst_pstrb", 32'(pstrb), 0);
    checkOutput("rst_mrdata", mrdata, 0);
    checkOutput("rst_mready", 32'(mready), 1);
    arst = 1'b0;
    idleCycles(1);

    // Read with immediate pready: mack at N+3.
    applyStimulus(5'h04, 1'b0, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0);
    idleCycles(1);
    checkOutput("ack_pulse_width", 32'(mack), 0);
    checkOutput("rdata_hold", mrdata, 32'hDEADBEEF);
    checkOutput("resp_hold", 32'(mresp), 0);

    // Write with pready delayed 3 cycles; prdata must not leak into mrdata.
    applyStimulus(5'h08, 1'b1, 32'h12345678, 4'hF, 3, 32'hCAFEF00D, 1'b0);
    idleCycles(1);

    // Read with error response.
    applyStimulus(5'h10, 1'b0, 32'h0, 4'h0, 1, 32'h0BADF00D, 1'b1);
    idleCycles(1);

    // Back-to-back: the second request is issued in the first mack cycle.
    applyStimulus(5'h1C, 1'b1, 32'hA5A55A5A, 4'h5, 0, 32'h0, 1'b0);
    applyStimulus(5'h03, 1'b0, 32'h0, 4'h0, 2, 32'h01234567, 1'b0);
    idleCycles(2);
    checkOutput("b2b_rdata_hold", mrdata, 32'h01234567);
    checkOutput("b2b_resp_hold", 32'(mresp), 0);

    // Reset during ACCESS: immediate abort, no completion.
    mreq = 1'b1; maddr = 5'h15; mwe = 1'b0;
    @(posedge clk);
    #1;
    mreq = 1'b0; pready = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("pre_rst_psel", 32'(psel), 1);
    checkOutput("pre_rst_penable", 32'(penable), 1);
    #2;
    arst = 1'b1;
    #1;
    checkOutput("async_rst_psel", 32'(psel), 0);
    checkOutput("async_rst_penable", 32'(penable), 0);
    checkOutput("async_rst_paddr", 32'(paddr), 0);
    checkOutput("async_rst_mack", 32'(mack), 0);
    @(posedge clk);
    #1;
    arst = 1'b0;
    last_wdata = '0;
    idleCycles(2);
    checkOutput("post_rst_mack", 32'(mack), 0);

    // Clean transfers after reset; the read must keep the last write data.
    applyStimulus(5'h1F, 1'b1, 32'hFFFF0000, 4'hC, 1, 32'h0, 1'b0);
    idleCycles(1);
    applyStimulus(5'h02, 1'b0, 32'h0, 4'h0, 0, 32'h55AA55AA, 1'b0);
    idleCycles(1);

`ifdef APB_TIMEOUT_EN
    // pready never arrives: expect 16 ACCESS cycles, then an error completion.
    begin
      int access_cycles;
      access_cycles = 0;
      exp_q.push_back({1'b1, 32'h0});
      mreq = 1'b1; maddr = 5'h0A; mwe = 1'b0;
      @(posedge clk);
      #1;
      mreq = 1'b0; pready = 1'b0; prdata = 32'h77777777;
      @(posedge clk);
      #1;
      for (int i = 0; i < 40 && psel === 1'b1; i++) begin
        if (penable === 1'b1) access_cycles++;
        @(posedge clk);
        #1;
      end
      checkOutput("timeout_access_cycles", 32'(access_cycles), 16);
      checkOutput("timeout_psel", 32'(psel), 0);
      checkOutput("timeout_mack", 32'(mack), 1);
      prdata = '0;
      idleCycles(1);
    end
`endif

    idleCycles(3);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
